// File: rtl/pinky_faddsub.sv
// PinKY multi-cycle float add/subtract unit (addf/subf).
// Float format: sign[15], exponent[14:7] (bias 127), mantissa[6:0] with an implied leading 1.
// Fixed five-state sequence, so every operation has the same latency; specials are carried through unchanged.
module pinky_faddsub #(
  parameter int unsigned GUARD = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic [15:0] result,
  output logic        done,
  output logic        busy
);

  localparam int unsigned SW = 8 + GUARD;  // significand width: hidden bit + 7 mantissa bits + guard bits

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]   r_op1;
  logic [15:0]   r_op2;
  logic          r_sub;
  logic [7:0]    r_ea;
  logic [7:0]    r_eb;
  logic [SW-1:0] r_siga;
  logic [SW-1:0] r_sigb;
  logic [SW:0]   r_sum;
  logic          r_sign;
  logic          r_eff_sub;
  logic          r_special;
  logic [15:0]   r_spec_val;
  logic [15:0]   r_result;
  logic          r_done;
  logic          r_busy;

  // Unpack/compare wires
  logic [7:0]    w_e1;
  logic [7:0]    w_e2;
  logic          w_z1;
  logic          w_z2;
  logic          w_s2;
  logic [14:0]   w_key1;
  logic [14:0]   w_key2;
  logic          w_swap;
  logic [SW-1:0] w_sig1;
  logic [SW-1:0] w_sig2;
  logic          w_special;
  logic [15:0]   w_spec_val;

  // Align wire
  logic [7:0]    w_diff;

  // Normalize/pack wires
  logic          w_carry;
  logic [SW-1:0] w_low;
  logic [4:0]    w_lz;
  logic [SW-1:0] w_shifted;
  logic signed [9:0] w_exp;
  logic [6:0]    w_mant;
  logic [15:0]   w_norm_result;

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

  // Leading-zero count over a 16-bit word; returns 16 for an all-zero word.
  function automatic logic [4:0] lzc16(input logic [15:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd16;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(15 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: linear walk through the stages, start only honoured in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_UNPACK;
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ADD;
      S_ADD:    w_next = S_NORM;
      S_NORM:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Unpack: zero detection, significand build, magnitude swap and special detection
  always_comb begin
    w_e1       = r_op1[14:7];
    w_e2       = r_op2[14:7];
    w_z1       = (w_e1 == 8'h00);
    w_z2       = (w_e2 == 8'h00);
    w_s2       = r_op2[15] ^ r_sub;
    w_key1     = w_z1 ? 15'h0000 : r_op1[14:0];
    w_key2     = w_z2 ? 15'h0000 : r_op2[14:0];
    w_swap     = (w_key2 > w_key1);
    w_sig1     = w_z1 ? '0 : {1'b1, r_op1[6:0], {GUARD{1'b0}}};
    w_sig2     = w_z2 ? '0 : {1'b1, r_op2[6:0], {GUARD{1'b0}}};
    w_special  = (w_e1 == 8'hFF) || (w_e2 == 8'hFF);
    w_spec_val = (w_e1 == 8'hFF) ? r_op1 : {w_s2, r_op2[14:0]};
  end

  assign w_diff = r_ea - r_eb;

  // Normalize and pack the sum, with zero, overflow and underflow handling
  always_comb begin
    w_carry   = r_sum[SW];
    w_low     = r_sum[SW-1:0];
    w_lz      = lzc16({w_low, {(16 - SW){1'b0}}});
    w_shifted = w_low << w_lz;
    if (w_carry) begin
      w_exp  = $signed({2'b00, r_ea}) + 10'sd1;
      w_mant = 7'(r_sum >> (GUARD + 1));
    end else begin
      w_exp  = $signed({2'b00, r_ea}) - $signed({5'b00000, w_lz});
      w_mant = 7'(w_shifted >> GUARD);
    end
    if (r_special)               w_norm_result = r_spec_val;
    else if (r_sum == '0)        w_norm_result = 16'h0000;
    else if (w_exp > 10'sd254)   w_norm_result = {r_sign, 8'hFF, 7'h00};
    else if (w_exp <= 10'sd0)    w_norm_result = 16'h0000;
    else                         w_norm_result = {r_sign, w_exp[7:0], w_mant};
  end

  // Datapath and registered handshake outputs, advanced per state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_sub      <= 1'b0;
      r_ea       <= '0;
      r_eb       <= '0;
      r_siga     <= '0;
      r_sigb     <= '0;
      r_sum      <= '0;
      r_sign     <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op1  <= op1;
            r_op2  <= op2;
            r_sub  <= sub;
            r_busy <= 1'b1;
          end
        end
        S_UNPACK: begin
          r_ea       <= w_swap ? w_e2 : w_e1;
          r_eb       <= w_swap ? w_e1 : w_e2;
          r_siga     <= w_swap ? w_sig2 : w_sig1;
          r_sigb     <= w_swap ? w_sig1 : w_sig2;
          r_sign     <= w_swap ? w_s2 : r_op1[15];
          r_eff_sub  <= r_op1[15] ^ w_s2;
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
        end
        S_ALIGN: begin
          if (w_diff >= 8'(SW)) r_sigb <= '0;
          else                  r_sigb <= r_sigb >> w_diff;
        end
        S_ADD: begin
          if (r_eff_sub) r_sum <= {1'b0, r_siga} - {1'b0, r_sigb};
          else           r_sum <= {1'b0, r_siga} + {1'b0, r_sigb};
        end
        S_NORM: begin
          r_result <= w_norm_result;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
